// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter:
// FSM encoding and the nibble correction / digit-valid constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CORR  = 2'd2,
        FIN   = 2'd3
    } state_e;

    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_AMT    = 4'd3;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;

endpackage

// File: rtl/bcd_nibble_sub3.sv
// Reverse double-dabble correction for one BCD digit: a nibble that
// picked up a shifted-in 1 (value >= 8) is pulled back down by 3.
module bcd_nibble_sub3
    import bcd_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    always_comb begin
        nib_out = nib_in;
        if (nib_in >= CORR_THRESH)
            nib_out = nib_in - CORR_AMT;
    end

endmodule

// File: rtl/bcd_to_bin_conv.sv
// Iterative packed-BCD to binary converter (reverse double-dabble), one
// shift or correction per cycle. Optional input digit check: BCD_CHECK_EN.
module bcd_to_bin_conv
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int W_W   = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_e                    state_q, state_d;
    logic [W_W-1:0]            w_q, w_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIN_W-1:0]          bin_out_q, bin_out_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      in_bad;

    logic [DIGITS-1:0][3:0]    nib_cur, nib_corr;

    assign nib_cur = w_q[W_W-1 -: BCD_W];

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_nibble_sub3 u_sub3 (
            .nib_in  (nib_cur[g]),
            .nib_out (nib_corr[g])
        );
    end

`ifdef BCD_CHECK_EN
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_in[4*i +: 4] > DIGIT_MAX)
                in_bad = 1'b1;
    end
`else
    assign in_bad = 1'b0;
`endif

    // State register (also holds the datapath flops).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            w_q       <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; the final shift goes straight to FIN, skipping CORR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !in_bad) state_d = SHIFT;
            SHIFT:   state_d = (cnt_q == CNT_W'(1)) ? FIN : CORR;
            CORR:    state_d = SHIFT;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output logic.
    always_comb begin
        w_d       = w_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (in_bad) begin
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        bin_out_d = '0;
                    end else begin
                        w_d   = {bcd_in, {BIN_W{1'b0}}};
                        cnt_d = CNT_W'(BIN_W);
                    end
                end
            end
            SHIFT: begin
                w_d   = {1'b0, w_q[W_W-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
            end
            CORR: begin
                w_d = {nib_corr, w_q[BIN_W-1:0]};
            end
            FIN: begin
                bin_out_d = w_q[BIN_W-1:0];
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign bin_out = bin_out_q;
    assign err     = err_q;

endmodule
